mem_responder: RTL and testbench

Main-memory responder for the data-cache controller. It accepts single-word write-back (`mem_wEn`) and refill (`mem_rEn`) requests and completes each one after a fixed, programmable latency. Completion is signalled by a one-cycle `mem_ready` pulse; on reads, refill data is presented on `refill`. The block serves as the backing store in simulation and in FPGA builds.

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency single-word memory responder used as the cache controller's backing store.
// One request is accepted in IDLE; completion is a one-cycle mem_ready pulse in RESP.
module mem_responder #(
  parameter int unsigned LATENCY     = 5,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] INIT_WORD   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rEn,
  input  logic        mem_wEn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] refill,
  output logic        busy,
  output logic        proto_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);
  localparam bit          SKIP_WAIT = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    cnt, cnt_next;
  logic          op_write, op_write_next;
  logic [AW-1:0] idx, idx_next;
  logic [31:0]   wdata, wdata_next;
  logic          proto_next;
  logic          enter_resp;

  // Content survives reset; it is only set at configuration time.
  logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    op_write_next = op_write;
    idx_next      = idx;
    wdata_next    = wdata;
    proto_next    = proto_err;

    case (state)
      IDLE: begin
        if (mem_wEn) begin
          op_write_next = 1'b1;
          idx_next      = mem_addr[AW+1:2];
          wdata_next    = mem_wdata;
          cnt_next      = CNT_LOAD;
          state_next    = SKIP_WAIT ? RESP : WAIT;
          if (mem_rEn) begin
            proto_next = 1'b1;
          end
        end else if (mem_rEn) begin
          op_write_next = 1'b0;
          idx_next      = mem_addr[AW+1:2];
          wdata_next    = mem_wdata;
          cnt_next      = CNT_LOAD;
          state_next    = SKIP_WAIT ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RESP is only ever entered from IDLE or WAIT, so this marks the committing edge.
  assign enter_resp = (state_next == RESP) && (state != RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      op_write  <= 1'b0;
      idx       <= '0;
      wdata     <= 32'h0;
      proto_err <= 1'b0;
      refill    <= 32'h0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      op_write  <= op_write_next;
      idx       <= idx_next;
      wdata     <= wdata_next;
      proto_err <= proto_next;
      if (enter_resp && !op_write_next) begin
        refill <= mem[idx_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_write_next) begin
      mem[idx_next] <= wdata_next;
    end
  end

  assign mem_ready = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=5 instance driven from a vector table and corner sequences,
// plus a LATENCY=1 instance for the back-to-back minimum-latency case.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        r5 = 1'b0, w5 = 1'b0;
  logic [31:0] addr5 = 32'h0, wd5 = 32'h0;
  logic        ready5, busy5, perr5;
  logic [31:0] refill5;

  logic        r1 = 1'b0, w1 = 1'b0;
  logic [31:0] addr1 = 32'h0, wd1 = 32'h0;
  logic        ready1, busy1, perr1;
  logic [31:0] refill1;

  int checks = 0;
  int failures = 0;
  int ready_count5 = 0;
  int ready_count1 = 0;

  logic [31:0] sb5[$];
  logic [31:0] sb1[$];

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_refill;
    logic        exp_proto;
  } vec_t;

  vec_t vecs[6];

  mem_responder #(.LATENCY(5), .DEPTH_WORDS(1024), .INIT_WORD(32'hDEADBEEF)) dut5 (
    .clk(clk), .rst(rst), .mem_rEn(r5), .mem_wEn(w5), .mem_addr(addr5),
    .mem_wdata(wd5), .mem_ready(ready5), .refill(refill5), .busy(busy5), .proto_err(perr5)
  );

  mem_responder #(.LATENCY(1), .DEPTH_WORDS(1024), .INIT_WORD(32'hDEADBEEF)) dut1 (
    .clk(clk), .rst(rst), .mem_rEn(r1), .mem_wEn(w1), .mem_addr(addr1),
    .mem_wdata(wd1), .mem_ready(ready1), .refill(refill1), .busy(busy1), .proto_err(perr1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel1, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    if (sel1) begin
      r1 = rd; w1 = wr; addr1 = a; wd1 = d;
    end else begin
      r5 = rd; w5 = wr; addr5 = a; wd5 = d;
    end
  endtask

  // Every mem_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready5) begin
      ready_count5++;
      if (sb5.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL ready5_unexpected: got pulse, expected none (refill %h)", refill5);
      end else begin
        checkOutput("refill5", refill5, sb5.pop_front());
      end
    end
    if (!rst && ready1) begin
      ready_count1++;
      if (sb1.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL ready1_unexpected: got pulse, expected none (refill %h)", refill1);
      end else begin
        checkOutput("refill1", refill1, sb1.pop_front());
      end
    end
  end

  // One full request: accept, measure latency, check single pulse and idle afterwards.
  task automatic doOp(input bit sel1, input string name, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_refill, input logic exp_proto);
    int k;
    int lat;
    lat = sel1 ? 1 : 5;
    if (sel1) sb1.push_back(exp_refill);
    else      sb5.push_back(exp_refill);
    @(negedge clk);
    applyStimulus(sel1, rd, wr, a, d);
    @(posedge clk); #1;
    applyStimulus(sel1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput({name, "_busy"}, sel1 ? busy1 : busy5, 1'b1);
    k = 1;
    while (!(sel1 ? ready1 : ready5) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({name, "_latency"}, 32'(k), 32'(lat));
    checkOutput({name, "_proto"}, sel1 ? perr1 : perr5, exp_proto);
    @(posedge clk); #1;
    checkOutput({name, "_ready_low"}, sel1 ? ready1 : ready5, 1'b0);
    checkOutput({name, "_idle"}, sel1 ? busy1 : busy5, 1'b0);
  endtask

  initial begin
    int base;

    vecs[0] = '{"rd_unwritten", 1'b1, 1'b0, 32'h55555555, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1] = '{"wr_40",        1'b0, 1'b1, 32'h00000040, 32'h12345678, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{"rd_40",        1'b1, 1'b0, 32'h00000040, 32'h0,        32'h12345678, 1'b0};
    vecs[3] = '{"rd_alias_1040",1'b1, 1'b0, 32'h00001040, 32'h0,        32'h12345678, 1'b0};
    vecs[4] = '{"both_8",       1'b1, 1'b1, 32'h00000008, 32'h0F0F0F0F, 32'h12345678, 1'b1};
    vecs[5] = '{"rd_8",         1'b1, 1'b0, 32'h00000008, 32'h0,        32'h0F0F0F0F, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", ready5, 1'b0);
    checkOutput("reset_refill", refill5, 32'h0);
    checkOutput("reset_busy", busy5, 1'b0);
    checkOutput("reset_proto", perr5, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      doOp(1'b0, vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_refill, vecs[i].exp_proto);
    end

    // Write arriving during WAIT of a read must be dropped entirely.
    base = ready_count5;
    sb5.push_back(32'hDEADBEEF);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4, 32'hAAAA5555);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("ignored_ready_count", 32'(ready_count5 - base), 32'd1);
    checkOutput("ignored_proto_sticky", perr5, 1'b1);
    doOp(1'b0, "rd_4_after_ignored", 1'b1, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 1'b1);

    // Reset in WAIT abandons the write and restores every output.
    base = ready_count5;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 32'hCAFEF00D);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_ready", ready5, 1'b0);
    checkOutput("midrst_refill", refill5, 32'h0);
    checkOutput("midrst_busy", busy5, 1'b0);
    checkOutput("midrst_proto", perr5, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrst_no_ready", 32'(ready_count5 - base), 32'd0);
    doOp(1'b0, "rd_C_after_rst", 1'b1, 1'b0, 32'hC, 32'h0, 32'hDEADBEEF, 1'b0);

    // Request in the same cycle as reset is dropped.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_req_busy", busy5, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_req_busy_later", busy5, 1'b0);

    // LATENCY=1: write, then back-to-back reads with request held high.
    doOp(1'b1, "l1_wr_4", 1'b0, 1'b1, 32'h4, 32'h11112222, 32'h0, 1'b0);
    base = ready_count1;
    sb1.push_back(32'hDEADBEEF);
    sb1.push_back(32'h11112222);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    checkOutput("l1_first_ready", ready1, 1'b1);
    @(posedge clk); #1;
    checkOutput("l1_gap_ready", ready1, 1'b0);
    checkOutput("l1_gap_busy", busy1, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("l1_second_ready", ready1, 1'b1);
    checkOutput("l1_second_refill", refill1, 32'h11112222);
    @(posedge clk); #1;
    checkOutput("l1_done_ready", ready1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("l1_ready_count", 32'(ready_count1 - base), 32'd2);

    checkOutput("sb5_drained", 32'(sb5.size()), 32'd0);
    checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
